// File: rtl/owm_pkg.sv
// Shared timing defaults, counter width and state encoding for the 1-wire bit controller.
package owm_pkg;

    localparam int CNT_W = 10;

    // Standard-speed slot timing, all in microseconds.
    localparam int T_RST_DEF  = 480;
    localparam int T_PRS_DEF  = 70;
    localparam int T_LOW0_DEF = 60;
    localparam int T_LOW1_DEF = 6;
    localparam int T_SMP_DEF  = 15;
    localparam int T_SLOT_DEF = 70;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        BIT  = 2'd2
    } state_e;

endpackage

// File: rtl/owm_tick.sv
// Microsecond prescaler: counts 0..CDR-1 and flags the last count as the tick.
module owm_tick #(
    parameter int CDR = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int PW = (CDR > 1) ? $clog2(CDR) : 1;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = (pre_q == PW'(CDR - 1));

    always_comb begin
        if (clr || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/owm_bit_ctrl.sv
// 1-wire master bit sequencer: runs one reset/presence or bit slot per accepted command.
module owm_bit_ctrl
    import owm_pkg::*;
#(
    parameter int FRQ    = 24000000,
    parameter int T_RST  = T_RST_DEF,
    parameter int T_PRS  = T_PRS_DEF,
    parameter int T_LOW0 = T_LOW0_DEF,
    parameter int T_LOW1 = T_LOW1_DEF,
    parameter int T_SMP  = T_SMP_DEF,
    parameter int T_SLOT = T_SLOT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_rst,
    input  logic cmd_dat,
    output logic rsp_valid,
    output logic rsp_dat,
    output logic rsp_prs,
    output logic rsp_err,
    output logic owr_oe,
    input  logic owr_i
);

    localparam int CDR = FRQ / 1000000;

    localparam logic [CNT_W-1:0] C_LOW_RST = CNT_W'(T_RST);
    localparam logic [CNT_W-1:0] C_LOW0    = CNT_W'(T_LOW0);
    localparam logic [CNT_W-1:0] C_LOW1    = CNT_W'(T_LOW1);
    localparam logic [CNT_W-1:0] C_SMP_BIT = CNT_W'(T_SMP);
    localparam logic [CNT_W-1:0] C_SMP_RST = CNT_W'(T_RST + T_PRS);
    localparam logic [CNT_W-1:0] C_END_BIT = CNT_W'(T_SLOT);
    localparam logic [CNT_W-1:0] C_END_RST = CNT_W'(2 * T_RST);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic             dat_q, dat_d;
    logic             smp_q, smp_d;
    logic             oe_q, oe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_dat_q, rsp_dat_d;
    logic             rsp_prs_q, rsp_prs_d;
    logic             rsp_err_q, rsp_err_d;

    logic             owr_s;
    logic             accept;
    logic             tick;
    logic             is_rst;
    logic [CNT_W-1:0] t_low;
    logic [CNT_W-1:0] t_smp;
    logic [CNT_W-1:0] t_end;

    assign owr_s     = sync_q[1];
    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign owr_oe    = oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_prs   = rsp_prs_q;
    assign rsp_err   = rsp_err_q;

    owm_tick #(
        .CDR (CDR)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    // Slot shape is fixed by the slot kind and the latched data bit.
    assign is_rst = (state_q == RST);
    assign t_low  = is_rst ? C_LOW_RST : (dat_q ? C_LOW1 : C_LOW0);
    assign t_smp  = is_rst ? C_SMP_RST : C_SMP_BIT;
    assign t_end  = is_rst ? C_END_RST : C_END_BIT;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dat_d       = dat_q;
        smp_d       = smp_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_prs_d   = rsp_prs_q;
        rsp_err_d   = rsp_err_q;
        sync_d      = {sync_q[0], owr_i};

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_rst ? RST : BIT;
                    dat_d   = cmd_dat;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                oe_d = (cnt_d < t_low);
                // Presence is active-low on the bus; the bit value is the bus level.
                if (tick && (cnt_d == t_smp)) begin
                    smp_d = is_rst ? ~owr_s : owr_s;
                end
                if (tick && (cnt_d == t_end)) begin
                    state_d     = IDLE;
                    oe_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~owr_s;
                    rsp_dat_d   = is_rst ? 1'b0 : smp_q;
                    rsp_prs_d   = is_rst ? smp_q : 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync_q      <= 2'b11;
            dat_q       <= 1'b0;
            smp_q       <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 1'b0;
            rsp_prs_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            dat_q       <= dat_d;
            smp_q       <= smp_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_prs_q   <= rsp_prs_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_owm_bit_ctrl.sv
// Scoreboard bench for owm_bit_ctrl at CDR=4 with a pull-up bus and a scripted slave.
module tb_owm_bit_ctrl;
    import owm_pkg::*;

    localparam int FRQ = 4000000;
    localparam int CDR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_rst = 1'b0;
    logic cmd_dat = 1'b0;
    logic cmd_ready, rsp_valid, rsp_dat, rsp_prs, rsp_err, owr_oe, owr_i;

    typedef struct {
        logic dat;
        logic prs;
        logic err;
        int   lat;
        int   oe_len;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   mode = 0;
    int   rel;
    logic slave_low;
    logic b2b = 1'b0;

    always #5 clk = ~clk;

    owm_bit_ctrl #(
        .FRQ (FRQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rst   (cmd_rst),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_prs   (rsp_prs),
        .rsp_err   (rsp_err),
        .owr_oe    (owr_oe),
        .owr_i     (owr_i)
    );

    // Slave behaviour, timed in clocks from the accepting edge.
    assign rel = cyc - acc_cyc;
    always_comb begin
        slave_low = 1'b0;
        case (mode)
            1: slave_low = (rel >= 1980) && (rel < 2400);
            2: slave_low = (rel >= 0) && (rel < 120);
            3: slave_low = 1'b1;
            default: ;
        endcase
    end
    assign owr_i = ~(owr_oe | slave_low);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int   oe_start = 0;
    int   oe_len = -1;
    int   last_b2b = -1;
    logic oe_prev = 1'b0;

    // Monitor: measures owr_oe width and compares every response against the scoreboard.
    always @(negedge clk) begin
        if (owr_oe && !oe_prev) oe_start = cyc;
        if (!owr_oe && oe_prev) oe_len = cyc - oe_start;
        oe_prev = owr_oe;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_dat", rsp_dat, mon_e.dat);
                check("rsp_prs", rsp_prs, mon_e.prs);
                check("rsp_err", rsp_err, mon_e.err);
                check("latency", cyc + 1 - acc_cyc, mon_e.lat);
                check("oe_len", oe_len, mon_e.oe_len);
                check("ready_at_rsp", cmd_ready, 1);
            end
            oe_len = -1;
            if (b2b && last_b2b >= 0) check("b2b_spacing", cyc - last_b2b, T_SLOT_DEF * CDR + 1);
            last_b2b = b2b ? cyc : -1;
        end
        if (cmd_valid && cmd_ready && rst_n) acc_cyc = cyc + 1;
    end

    task automatic send(input logic r, input logic d, input logic e_dat, input logic e_prs,
                        input logic e_err, input logic keep, input logic push);
        exp_t e;
        int   n;
        e.dat    = e_dat;
        e.prs    = e_prs;
        e.err    = e_err;
        e.lat    = r ? 2 * T_RST_DEF * CDR + 1 : T_SLOT_DEF * CDR + 1;
        e.oe_len = (r ? T_RST_DEF : (d ? T_LOW1_DEF : T_LOW0_DEF)) * CDR;
        if (push) sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_rst   = r;
        cmd_dat   = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 10000) begin
                check("accept_timeout", 0, 1);
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
        @(negedge clk);
        check("busy_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [7:0] pattern;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_oe", owr_oe, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_dat", rsp_dat, 0);
        check("rst_prs", rsp_prs, 0);
        check("rst_err", rsp_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        mode = 1; send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); wait_idle();
        mode = 0; send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); wait_idle();
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); wait_idle();
        send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); wait_idle();
        mode = 2; send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); wait_idle();
        mode = 3; send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); wait_idle();
        mode = 0;
        repeat (5) @(posedge clk);
        #1;

        b2b = 1'b1;
        pattern = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, pattern[i], pattern[i], 1'b0, 1'b0, (i < 7), 1'b1);
        end
        wait_idle();
        b2b = 1'b0;

        // Reset in the middle of a write-0 slot: no response may appear.
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (cyc - acc_cyc < 100) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_oe", owr_oe, 1);
        rst_n = 1'b0;
        #1;
        check("async_oe", owr_oe, 0);
        check("async_ready", cmd_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("post_ready", cmd_ready, 1);
        check("post_oe", owr_oe, 0);
        check("post_valid", rsp_valid, 0);
        check("post_dat", rsp_dat, 0);
        check("post_prs", rsp_prs, 0);
        check("post_err", rsp_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/owm_bit_ctrl.md
Name: owm_bit_ctrl

Overview:
- Bit-level 1-wire master sequencer for the on-board 1-wire bus, driven through an open-drain enable (owr_oe) and a line readback (owr_i).
- Accepts one command at a time from a CPU-side register block or byte engine:
  - reset/presence slot, or
  - single-bit slot, where write-1 doubles as read.
- Generates standard-speed slot timing from the system clock and returns the sampled bit, presence and a bus-stuck-low flag.

Parameters:
- FRQ, 24000000, system clock frequency in Hz; CDR = FRQ/1000000 clocks per 1 us tick; CDR >= 2 required.
- T_RST, 480, reset low time in us; the total reset slot is 2*T_RST.
- T_PRS, 70, presence sample point, in us after reset release.
- T_LOW0, 60, write-0 low time in us.
- T_LOW1, 6, write-1/read low time in us.
- T_SMP, 15, bit sample point in us from slot start.
- T_SLOT, 70, bit slot length in us, including recovery.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle, command accepted on valid&ready
- cmd_rst  in  1  1 = reset/presence slot, 0 = bit slot
- cmd_dat  in  1  bit to transmit (1 also = read)
- rsp_valid  out  1  one-cycle pulse at slot end
- rsp_dat  out  1  sampled bit (bit slot); 0 for reset slot
- rsp_prs  out  1  presence detected (reset slot); 0 for bit slot
- rsp_err  out  1  line low at slot end (bus short)
- owr_oe  out  1  1 = pull bus low
- owr_i  in  1  bus level, asynchronous

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE; cmd_ready=1; owr_oe=0.
  - rsp_valid=0, rsp_dat=0, rsp_prs=0, rsp_err=0.
  - Prescaler and us counter 0; synchronizer flops 1.
- owr_i input path: 2-flop synchronizer into owr_s. All sampling uses owr_s.
- States:
  - IDLE, RST and BIT.
  - IDLE -> RST or BIT on the accepting edge, selected by cmd_rst; cmd_dat is latched.
  - RST and BIT return to IDLE at slot end.
  - Commands presented while busy stall; they are neither dropped nor queued.
- Timebase:
  - The prescaler clears on accept and counts 0..CDR-1.
  - tick = (pre == CDR-1).
  - us counter cnt, 10 bits, clears on accept and increments on tick.
- owr_oe (registered):
  - Rises on the cycle after accept.
  - Stays high while cnt < T_LOW, where T_LOW = T_RST for RST, T_LOW0 for BIT with dat=0, T_LOW1 for BIT with dat=1.
  - High duration is exactly T_LOW*CDR cycles.
- Sampling:
  - BIT: at the tick where cnt becomes T_SMP, rsp_dat <= owr_s.
  - RST: at the tick where cnt becomes T_RST+T_PRS, rsp_prs <= ~owr_s.
- Slot end:
  - At the tick where cnt becomes T_SLOT (BIT) or 2*T_RST (RST): rsp_err <= ~owr_s, rsp_valid pulses for 1 cycle, state -> IDLE.
  - cmd_ready is high again on the same cycle as rsp_valid.
  - rsp_valid pulses exactly T_SLOT*CDR+1 (BIT) or 2*T_RST*CDR+1 (RST) cycles after the accepting edge.
- Response fields:
  - rsp_dat, rsp_prs and rsp_err hold until the next slot end. The field not relevant to the slot is written 0.
  - No response backpressure.
- Back-to-back commands: a command accepted in the rsp_valid cycle starts immediately. owr_oe rises the next cycle, giving no extra idle time.
- Reset mid-slot: owr_oe drops to 0 asynchronously; no rsp_valid is emitted.
- Line held low externally during a bit slot: rsp_dat=0, rsp_err=1, timing unchanged.

Decomposition:
- Package owm_pkg holds:
  - timing defaults (T_RST, T_PRS, T_LOW0, T_LOW1, T_SMP, T_SLOT);
  - the state enum (IDLE, RST, BIT);
  - the counter width constant (10).
- One sub-module, owm_tick: the CDR-cycle prescaler with synchronous clear and tick output.
- The synchronizer and FSM stay inline.

Test Plan:
All scenarios use FRQ=4000000 (CDR=4) and a pull-up bus model.
1. Reset slot, slave pulls low 15..120 us after release: owr_oe high 1920 cycles; rsp_valid at cycle 3841; rsp_prs=1, rsp_err=0.
2. Reset slot, no slave: rsp_prs=0 at cycle 3841; cmd_ready=1 that cycle.
3. Bit slot dat=0: owr_oe high 240 cycles; rsp_valid at cycle 281; rsp_dat=0, rsp_err=0. Bit slot dat=1, slave idle: oe high 24 cycles; rsp_dat=1.
4. Read with slave holding low 0..30 us: rsp_dat=0, rsp_err=0. Bus held low whole slot: rsp_dat=0, rsp_err=1.
5. Back-to-back: cmd_valid held for 8 bit commands (pattern 0xA5) → eight rsp_valid pulses spaced exactly 281 cycles; cmd_valid asserted while busy → cmd_ready=0, no accept.
6. Assert rst_n=0 at cycle 100 of a write-0 slot: owr_oe=0 in the same cycle; no rsp_valid; after release, state IDLE and all outputs at reset values.
